// File: rtl/decode_pkg.sv
// rtl/decode_pkg.sv - shared field positions, ALU opcodes and decoded entry type for decode_stage
package decode_pkg;

    localparam int IW = 32;
    localparam int DW = 16;

    localparam int FIRST_LD_HI  = 31;
    localparam int FIRST_LD_LO  = 30;
    localparam int SPECIAL_BIT  = 29;
    localparam int SECOND_LD_HI = 28;
    localparam int SECOND_LD_LO = 25;
    localparam int ALU_OC_HI    = 28;
    localparam int ALU_OC_LO    = 26;
    localparam int B_COND_HI    = 24;
    localparam int B_COND_LO    = 21;
    localparam int DEST_HI      = 24;
    localparam int DEST_LO      = 22;
    localparam int PTR_HI       = 21;
    localparam int PTR_LO       = 19;
    localparam int OP1_HI       = 21;
    localparam int OP1_LO       = 19;
    localparam int OP2_HI       = 18;
    localparam int OP2_LO       = 16;
    localparam int IMM_HI       = 15;
    localparam int IMM_LO       = 0;

    localparam logic [2:0] ALU_ADD = 3'b001;
    localparam logic [2:0] ALU_SUB = 3'b010;
    localparam logic [2:0] ALU_AND = 3'b011;
    localparam logic [2:0] ALU_OR  = 3'b100;
    localparam logic [2:0] ALU_XOR = 3'b101;
    localparam logic [2:0] ALU_NOT = 3'b110;

    typedef struct packed {
        logic [1:0]    first_ld;
        logic          special_enc;
        logic [3:0]    second_ld;
        logic [2:0]    alu_oc;
        logic [3:0]    b_cond;
        logic [2:0]    dest_reg;
        logic [2:0]    pointer_reg;
        logic [2:0]    op_1_reg;
        logic [2:0]    op_2_reg;
        logic [DW-1:0] immediate;
        logic [DW-1:0] offset;
        logic          is_nop;
        logic          illegal;
    } dec_entry_t;

    // Only the six defined ALU opcodes are legal; 000 and 111 are unassigned.
    function automatic logic alu_oc_illegal(input logic [2:0] oc);
        return !((oc == ALU_ADD) || (oc == ALU_SUB) || (oc == ALU_AND) ||
                 (oc == ALU_OR)  || (oc == ALU_XOR) || (oc == ALU_NOT));
    endfunction

endpackage

// File: rtl/decode_if.sv
// rtl/decode_if.sv - fetch-side and execute-side handshake plus decoded fields of decode_stage
interface decode_if #(
    parameter int IW = 32,
    parameter int DW = 16
);
    logic          in_valid;
    logic          in_ready;
    logic [IW-1:0] instr;

    logic          out_valid;
    logic          out_ready;
    logic [1:0]    first_ld;
    logic          special_enc;
    logic [3:0]    second_ld;
    logic [2:0]    alu_oc;
    logic [3:0]    b_cond;
    logic [2:0]    dest_reg;
    logic [2:0]    pointer_reg;
    logic [2:0]    op_1_reg;
    logic [2:0]    op_2_reg;
    logic [DW-1:0] immediate;
    logic [DW-1:0] offset;
    logic          is_nop;
    logic          illegal;

    modport slave (
        input  in_valid, instr, out_ready,
        output in_ready, out_valid, first_ld, special_enc, second_ld, alu_oc,
               b_cond, dest_reg, pointer_reg, op_1_reg, op_2_reg, immediate,
               offset, is_nop, illegal
    );

    modport master (
        output in_valid, instr, out_ready,
        input  in_ready, out_valid, first_ld, special_enc, second_ld, alu_oc,
               b_cond, dest_reg, pointer_reg, op_1_reg, op_2_reg, immediate,
               offset, is_nop, illegal
    );
endinterface

// File: rtl/decode_fields.sv
// rtl/decode_fields.sv - combinational split of one instruction word into a decoded entry
module decode_fields
    import decode_pkg::*;
(
    input  logic [IW-1:0] instr,
    output dec_entry_t    fields
);

    // Pure bit extraction plus the two derived flags.
    always_comb begin
        fields             = '0;
        fields.first_ld    = instr[FIRST_LD_HI:FIRST_LD_LO];
        fields.special_enc = instr[SPECIAL_BIT];
        fields.second_ld   = instr[SECOND_LD_HI:SECOND_LD_LO];
        fields.alu_oc      = instr[ALU_OC_HI:ALU_OC_LO];
        fields.b_cond      = instr[B_COND_HI:B_COND_LO];
        fields.dest_reg    = instr[DEST_HI:DEST_LO];
        fields.pointer_reg = instr[PTR_HI:PTR_LO];
        fields.op_1_reg    = instr[OP1_HI:OP1_LO];
        fields.op_2_reg    = instr[OP2_HI:OP2_LO];
        fields.immediate   = instr[IMM_HI:IMM_LO];
        fields.offset      = instr[IMM_HI:IMM_LO];
        fields.is_nop      = (instr == '0);
        fields.illegal     = instr[SPECIAL_BIT] && alu_oc_illegal(instr[ALU_OC_HI:ALU_OC_LO]);
    end

endmodule

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - instruction decode stage with 2-entry skid buffer (optional DECODE_PERF_CNT_EN counters)
module decode_stage
    import decode_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    decode_if.slave     bus
`ifdef DECODE_PERF_CNT_EN
    ,
    output logic [15:0] dec_count,
    output logic [15:0] illegal_count
`endif
);

    dec_entry_t fields_in;
    dec_entry_t main_q, main_d;
    dec_entry_t skid_q, skid_d;
    logic       main_v, main_v_d;
    logic       skid_v, skid_v_d;
    logic       accept;
    logic       consume;

    decode_fields u_fields (
        .instr  (bus.instr),
        .fields (fields_in)
    );

    // in_ready comes straight from the skid flag, so fetch never sees execute's ready.
    assign bus.in_ready  = !skid_v;
    assign bus.out_valid = main_v;
    assign accept        = bus.in_valid && !skid_v;
    assign consume       = main_v && bus.out_ready;

    assign bus.first_ld    = main_q.first_ld;
    assign bus.special_enc = main_q.special_enc;
    assign bus.second_ld   = main_q.second_ld;
    assign bus.alu_oc      = main_q.alu_oc;
    assign bus.b_cond      = main_q.b_cond;
    assign bus.dest_reg    = main_q.dest_reg;
    assign bus.pointer_reg = main_q.pointer_reg;
    assign bus.op_1_reg    = main_q.op_1_reg;
    assign bus.op_2_reg    = main_q.op_2_reg;
    assign bus.immediate   = main_q.immediate;
    assign bus.offset      = main_q.offset;
    assign bus.is_nop      = main_q.is_nop;
    assign bus.illegal     = main_q.illegal;

    // Next-state of the MAIN/SKID pair: refill MAIN from SKID first to keep order.
    always_comb begin
        main_d   = main_q;
        main_v_d = main_v;
        skid_d   = skid_q;
        skid_v_d = skid_v;
        if (!main_v || consume) begin
            if (skid_v) begin
                main_d   = skid_q;
                main_v_d = 1'b1;
                skid_v_d = accept;
                if (accept) begin
                    skid_d = fields_in;
                end
            end else begin
                main_v_d = accept;
                if (accept) begin
                    main_d = fields_in;
                end
            end
        end else if (accept) begin
            skid_d   = fields_in;
            skid_v_d = 1'b1;
        end
    end

    // Entry registers; flush behaves exactly like reset and overrides accept/consume.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            main_q <= '0;
            skid_q <= '0;
            main_v <= 1'b0;
            skid_v <= 1'b0;
        end else begin
            main_q <= main_d;
            skid_q <= skid_d;
            main_v <= main_v_d;
            skid_v <= skid_v_d;
        end
    end

`ifdef DECODE_PERF_CNT_EN
    // Saturating consume counters; they survive flush and clear only on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            dec_count     <= '0;
            illegal_count <= '0;
        end else if (consume && !flush) begin
            if (dec_count != 16'hFFFF) begin
                dec_count <= dec_count + 16'd1;
            end
            if (main_q.illegal && (illegal_count != 16'hFFFF)) begin
                illegal_count <= illegal_count + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - randomized scoreboard bench for decode_stage
module tb_decode_stage;

    logic clk;
    logic rst;
    logic flush;

    decode_if bus_if ();

`ifdef DECODE_PERF_CNT_EN
    logic [15:0] dec_count;
    logic [15:0] illegal_count;
`endif

    decode_stage dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus_if)
`ifdef DECODE_PERF_CNT_EN
        ,
        .dec_count     (dec_count),
        .illegal_count (illegal_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] exp_q[$];
    int          exp_dec = 0;
    int          exp_ill = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Expected decode computed from the field table with shifts and masks.
    function automatic logic [59:0] model(input logic [31:0] w);
        logic [1:0]  fl;
        logic        sp;
        logic [3:0]  sl;
        logic [2:0]  aoc;
        logic [3:0]  bc;
        logic [2:0]  dr;
        logic [2:0]  pr;
        logic [2:0]  o2;
        logic [15:0] imm;
        logic        nop;
        logic        ill;
        fl  = 2'((w >> 30) & 32'h3);
        sp  = ((w >> 29) & 32'h1) != 0;
        sl  = 4'((w >> 25) & 32'hF);
        aoc = 3'((w >> 26) & 32'h7);
        bc  = 4'((w >> 21) & 32'hF);
        dr  = 3'((w >> 22) & 32'h7);
        pr  = 3'((w >> 19) & 32'h7);
        o2  = 3'((w >> 16) & 32'h7);
        imm = 16'(w & 32'hFFFF);
        nop = (w == 32'h0);
        ill = sp && (aoc == 3'd0 || aoc == 3'd7);
        return {fl, sp, sl, aoc, bc, dr, pr, pr, o2, imm, imm, nop, ill};
    endfunction

    function automatic logic [59:0] dut_vec();
        return {bus_if.first_ld, bus_if.special_enc, bus_if.second_ld, bus_if.alu_oc,
                bus_if.b_cond, bus_if.dest_reg, bus_if.pointer_reg, bus_if.op_1_reg,
                bus_if.op_2_reg, bus_if.immediate, bus_if.offset, bus_if.is_nop,
                bus_if.illegal};
    endfunction

    // Monitor: occupancy checks, then pop/compare on consume, then push on accept.
    always @(negedge clk) begin
        logic [31:0] w;
        if (rst) begin
            exp_q.delete();
            exp_dec = 0;
            exp_ill = 0;
        end else begin
            chk("out_valid", 64'(bus_if.out_valid), 64'(exp_q.size() != 0));
            chk("in_ready", 64'(bus_if.in_ready), 64'(exp_q.size() < 2));
`ifdef DECODE_PERF_CNT_EN
            chk("dec_count", 64'(dec_count), 64'(exp_dec));
            chk("illegal_count", 64'(illegal_count), 64'(exp_ill));
`endif
            if (flush) begin
                exp_q.delete();
            end else begin
                if (bus_if.out_valid && bus_if.out_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("spurious_out", 64'(1), 64'(0));
                    end else begin
                        w = exp_q.pop_front();
                        chk($sformatf("fields[%h]", w), 64'(dut_vec()), 64'(model(w)));
                        if (exp_dec < 65535) exp_dec++;
                        if (model(w)[0] && exp_ill < 65535) exp_ill++;
                    end
                end
                if (bus_if.in_valid && bus_if.in_ready) begin
                    exp_q.push_back(bus_if.instr);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Hold a word on the input until the stage takes it, bounded.
    task automatic send(input logic [31:0] w);
        logic ok;
        bus_if.in_valid = 1'b1;
        bus_if.instr    = w;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            ok = bus_if.in_ready;
            tick();
        end
        if (!ok) chk("send_timeout", 64'(0), 64'(1));
        bus_if.in_valid = 1'b0;
    endtask

    task automatic drain();
        bus_if.in_valid  = 1'b0;
        bus_if.out_ready = 1'b1;
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
        repeat (2) tick();
        chk("drained", 64'(exp_q.size()), 64'(0));
    endtask

    function automatic logic [31:0] rand_word();
        int sel;
        logic [31:0] w;
        sel = int'($urandom_range(0, 7));
        w   = $urandom;
        if (sel == 0) w = 32'h0;
        else if (sel == 1) w = {w[31:30], 1'b1, ($urandom_range(0, 1) != 0) ? 3'b111 : 3'b000, w[25:0]};
        else if (sel == 2) w[29] = 1'b1;
        return w;
    endfunction

    initial begin
        rst = 1'b1;
        flush = 1'b0;
        bus_if.in_valid = 1'b0;
        bus_if.out_ready = 1'b0;
        bus_if.instr = 32'h0;
        repeat (3) tick();
        rst = 1'b0;
        @(negedge clk);
        #2;
        chk("reset_fields", 64'(dut_vec()), 64'(0));
        chk("reset_out_valid", 64'(bus_if.out_valid), 64'(0));
        chk("reset_in_ready", 64'(bus_if.in_ready), 64'(1));
        tick();

        // Directed words with execute always ready.
        bus_if.out_ready = 1'b1;
        send(32'hA498_0005);
        @(negedge clk);
        chk("a498_alu_oc", 64'(bus_if.alu_oc), 64'(3'b001));
        chk("a498_dest", 64'(bus_if.dest_reg), 64'(3'b010));
        chk("a498_op1", 64'(bus_if.op_1_reg), 64'(3'b011));
        tick();
        send(32'h0000_0000);
        send(32'h2000_0000);
        send(32'h3C00_0000);
        drain();

`ifdef DECODE_PERF_CNT_EN
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus_if.out_ready = 1'b1;
        send(32'h2000_0000);
        send(32'h1234_5678);
        send(32'h3C00_0001);
        send(32'h0000_0000);
        send(32'hA498_0005);
        drain();
        chk("perf_dec5", 64'(dec_count), 64'(5));
        chk("perf_ill2", 64'(illegal_count), 64'(2));
        flush = 1'b1;
        tick();
        flush = 1'b0;
        tick();
        chk("perf_dec_flush", 64'(dec_count), 64'(5));
        chk("perf_ill_flush", 64'(illegal_count), 64'(2));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("perf_dec_rst", 64'(dec_count), 64'(0));
        chk("perf_ill_rst", 64'(illegal_count), 64'(0));
        tick();
`endif

        // Stall: A in MAIN, B in SKID, C blocked until execute resumes.
        bus_if.out_ready = 1'b0;
        bus_if.in_valid  = 1'b1;
        bus_if.instr     = 32'hA498_0005;
        tick();
        bus_if.instr     = 32'h2000_1111;
        tick();
        bus_if.instr     = 32'h4ABC_2222;
        repeat (3) tick();
        @(negedge clk);
        chk("stall_in_ready", 64'(bus_if.in_ready), 64'(0));
        chk("stall_depth", 64'(exp_q.size()), 64'(2));
        tick();
        bus_if.out_ready = 1'b1;
        send(32'h4ABC_2222);
        drain();

        // Flush with SKID full and a word offered in the same cycle.
        bus_if.out_ready = 1'b0;
        send(32'h1111_0001);
        send(32'h2222_0002);
        bus_if.in_valid = 1'b1;
        bus_if.instr    = 32'hDEAD_BEEF;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        bus_if.in_valid = 1'b0;
        @(negedge clk);
        chk("flush_out_valid", 64'(bus_if.out_valid), 64'(0));
        chk("flush_in_ready", 64'(bus_if.in_ready), 64'(1));
        tick();
        drain();

        // Randomized traffic with occasional flushes.
        for (int c = 0; c < 3000; c++) begin
            bus_if.in_valid  = ($urandom_range(0, 3) != 0);
            bus_if.out_ready = ($urandom_range(0, 2) != 0);
            bus_if.instr     = rand_word();
            flush            = ($urandom_range(0, 39) == 0);
            tick();
        end
        flush = 1'b0;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
# decode_stage

Instruction decode stage for the single-issue 16-bit core. It accepts 32-bit instruction words from fetch over a valid/ready handshake and splits each word into the decode fields the execute stage consumes: first/second-level decode, special (ALU) encoding, ALU opcode, branch condition, register indices, immediate and offset. A 2-entry skid buffer sits between fetch and execute, so neither side's ready depends combinationally on the other. The stage also flags illegal ALU opcodes and supports a synchronous pipeline flush.

## Interface
Parameters:
- IW, 32, instruction word width; fixed, other values unsupported.
- DW, 16, immediate/offset width.

Ports:
- clk  in  1  core clock; all logic on rising edge.
- rst  in  1  reset; synchronous, active-high.
- flush  in  1  drop all buffered instructions (branch taken / redirect).
- in_valid  in  1  fetch presents instr.
- in_ready  out  1  stage can accept; registered.
- instr  in  32  instruction word.
- out_valid  out  1  decoded entry present.
- out_ready  in  1  execute consumes entry.
- first_ld  out  2  instr[31:30]; bit0=0 immediate form, bit0=1 register form.
- special_enc  out  1  instr[29]; 1 = ALU class.
- second_ld  out  4  instr[28:25]; meaningful when special_enc=0.
- alu_oc  out  3  instr[28:26]; meaningful when special_enc=1.
- b_cond  out  4  instr[24:21].
- dest_reg  out  3  instr[24:22].
- pointer_reg  out  3  instr[21:19].
- op_1_reg  out  3  instr[21:19].
- op_2_reg  out  3  instr[18:16].
- immediate  out  16  instr[15:0].
- offset  out  16  instr[15:0].
- is_nop  out  1  instr == 32'h0000_0000.
- illegal  out  1  special_enc=1 and alu_oc in {3'b000, 3'b111}.

## Operation
- Fields are extracted combinationally at capture and stored decoded; outputs drive straight from the main register.
- Two entries: MAIN (drives outputs, out_valid = main_v) and SKID (holds overflow, in_ready = !skid_v).
- Accept = in_valid & in_ready; consume = out_valid & out_ready.
- Per cycle, when not flushing:
  - MAIN empty or consumed: MAIN <= SKID if skid_v, else the accepted input; otherwise MAIN is emptied.
  - MAIN full and not consumed, with accept: the input goes to SKID.
  - SKID drained into MAIN with a simultaneous accept: the input goes into SKID.
- Illegal instructions pass through with illegal=1. Every field is still decoded, and no entry is dropped.
- is_nop and illegal are mutually exclusive (NOP has special_enc=0).
- Flush: main_v and skid_v clear next cycle and in_ready=1. Flush beats a same-cycle accept (the word is not captured) and a same-cycle consume.
- Reset: identical to flush. All decoded output fields reset to 0, out_valid=0, in_ready=1, counters 0.

## Timing
- Latency: an instruction accepted in cycle N appears on the outputs in cycle N+1 when MAIN is empty or consumed in N.
- Throughput: 1 instr/cycle with out_ready held high.
- in_ready drops the cycle after SKID fills and rises the cycle after SKID drains.
- Output fields stay stable while out_valid=1 and out_ready=0.
- in_valid may deassert without a handshake; instr is sampled only on accept.

## Configuration
- DECODE_PERF_CNT_EN defined:
  - Adds outputs dec_count[15:0], which increments on each consume, and illegal_count[15:0], which increments on each consume with illegal=1.
  - Both counters saturate at 16'hFFFF.
  - Both clear on rst only; flush does not clear them.
- DECODE_PERF_CNT_EN undefined: neither port nor counter logic exists.

## Structure
- Shared package decode_pkg holds:
  - field bit-position constants;
  - ALU opcode constants: ALU_ADD=3'b001, SUB=010, AND=011, OR=100, XOR=101, NOT=110;
  - a packed typedef dec_entry_t bundling all decoded outputs, used for MAIN and SKID.
- One combinational sub-module, decode_fields (instr -> dec_entry_t), instantiated once on the input path.

## Test plan
- Reset then instr=32'hA498_0005, in_valid=1, out_ready=1 -> next cycle out_valid=1, first_ld=2'b10, special_enc=1, alu_oc=3'b001, dest_reg=3'b010, op_1_reg=3'b011, immediate=16'h0005, illegal=0.
- instr=32'h0000_0000 -> is_nop=1, special_enc=0, illegal=0.
- instr=32'h2000_0000 (special, alu_oc=000) and 32'h3C00_0000 (alu_oc=111) -> illegal=1 for each, both delivered in order.
- out_ready=0 while streaming 3 words A,B,C -> A held in MAIN, B in SKID, in_ready=0 in the cycle after B's accept, C not accepted. Raise out_ready -> A,B,C emerge in order with no loss or duplication.
- SKID full, assert flush with in_valid=1 -> next cycle out_valid=0, in_ready=1, flushed word never appears.
- With DECODE_PERF_CNT_EN: consume 5 words, 2 of them illegal -> dec_count=5, illegal_count=2. After flush the counts are unchanged; after rst they read 0.
